sync_fifo: RTL and testbench

- Synchronous single-clock first-in first-out buffer for byte-wide data. Used in the buffered UART path between producer and consumer logic.
- Signals are grouped in the team's fifo_if interface bundle, parameterised by width and length.
- A behavioural reference model with an identical interface runs in lock-step against this block. It must match cycle-for-cycle on data_out, including reset and boundary cases.

---
 rtl/sync_fifo_if.sv | 27 ++
 rtl/sync_fifo.sv | 72 +++++++
 tb/tb_sync_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Signal bundle for the byte FIFO: data path, handshakes and status between producer/consumer and sync_fifo.
interface fifo_if #(
  parameter int unsigned width  = 8,
  parameter int unsigned length = 4
);
  localparam int unsigned count_w = $clog2(length + 1);

  logic [width-1:0]   data_in;
  logic               write_enable;
  logic               read_enable;
  logic [width-1:0]   data_out;
  logic               full;
  logic               empty;
  logic [count_w-1:0] count;
  logic               overflow;
  logic               underflow;

  modport dut (
    input  data_in, write_enable, read_enable,
    output data_out, full, empty, count, overflow, underflow
  );

  modport host (
    output data_in, write_enable, read_enable,
    input  data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and one-cycle overflow/underflow pulses.
module sync_fifo #(
  parameter int unsigned width  = 8,
  parameter int unsigned length = 4
) (
  input  logic clock,
  input  logic resetn,
  fifo_if.dut  bus
);

  localparam int unsigned count_w = $clog2(length + 1);
  localparam int unsigned ptr_w   = (length > 1) ? $clog2(length) : 1;

  logic [width-1:0]   mem [length];
  logic [ptr_w-1:0]   wp;
  logic [ptr_w-1:0]   rp;
  logic [count_w-1:0] count_q;
  logic [width-1:0]   data_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               full;
  logic               empty;
  logic               rd_acc;
  logic               wr_acc;

  assign full   = (count_q == count_w'(length));
  assign empty  = (count_q == '0);
  // A read frees a slot on the same edge, so a full FIFO still takes a paired write.
  assign rd_acc = bus.read_enable && !empty;
  assign wr_acc = bus.write_enable && (!full || rd_acc);

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.data_out  = data_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wp] <= bus.data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wp          <= '0;
      rp          <= '0;
      count_q     <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.write_enable && full && !rd_acc;
      underflow_q <= bus.read_enable && empty;
      if (wr_acc) begin
        if (wp == ptr_w'(length - 1)) wp <= '0;
        else                          wp <= wp + ptr_w'(1);
      end
      if (rd_acc) begin
        data_q <= mem[rp];
        if (rp == ptr_w'(length - 1)) rp <= '0;
        else                          rp <= rp + ptr_w'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + count_w'(1);
        2'b01:   count_q <= count_q - count_w'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomised checks of sync_fifo (width 8, length 4) against hand-computed values and a queue model.
module tb_sync_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned L = 4;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_err;

  fifo_if #(.width(W), .length(L)) bus ();

  sync_fifo #(.width(W), .length(L)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, then settle just after the rising edge.
  task automatic step(input logic we, input logic re, input logic [W-1:0] d);
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.data_in      = d;
    @(posedge clock);
    #1;
  endtask

  logic [W-1:0] model_q [$];
  logic [W-1:0] exp_dout;
  logic         exp_ovf;
  logic         exp_unf;
  logic         we_r;
  logic         re_r;
  logic [W-1:0] din_r;
  logic         rd_ok;
  logic         wr_ok;

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.data_in      = '0;
    #3;
    check("rst_dout",  32'(bus.data_out),  32'h0);
    check("rst_count", 32'(bus.count),     32'd0);
    check("rst_empty", 32'(bus.empty),     32'd1);
    check("rst_full",  32'(bus.full),      32'd0);
    check("rst_ovf",   32'(bus.overflow),  32'd0);
    check("rst_unf",   32'(bus.underflow), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Reset in the middle of traffic discards stored words.
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    bus.write_enable = 1'b0;
    resetn = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_full",  32'(bus.full),  32'd0);
    check("mid_rst_dout",  32'(bus.data_out), 32'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_unf",  32'(bus.underflow), 32'd1);
    check("post_rst_dout", 32'(bus.data_out),  32'h0);
    step(1'b0, 1'b0, 8'h00);
    check("unf_pulse_end", 32'(bus.underflow), 32'd0);

    // Fill, overflow, drain.
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd4);
    step(1'b1, 1'b0, 8'h55);
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count),    32'd4);
    step(1'b0, 1'b0, 8'h00);
    check("ovf_end",   32'(bus.overflow), 32'd0);
    check("dout_hold_fill", 32'(bus.data_out), 32'h0);
    step(1'b0, 1'b1, 8'h00);
    check("drain0", 32'(bus.data_out), 32'h11);
    step(1'b0, 1'b1, 8'h00);
    check("drain1", 32'(bus.data_out), 32'h22);
    step(1'b0, 1'b1, 8'h00);
    check("drain2", 32'(bus.data_out), 32'h33);
    step(1'b0, 1'b1, 8'h00);
    check("drain3", 32'(bus.data_out), 32'h44);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_unf",   32'(bus.underflow), 32'd0);

    // Read on empty holds data_out.
    step(1'b0, 1'b1, 8'h00);
    check("unf_pulse", 32'(bus.underflow), 32'd1);
    check("unf_hold",  32'(bus.data_out),  32'h44);

    // Read+write on empty: write taken, read rejected.
    step(1'b1, 1'b1, 8'h77);
    check("rw_empty_unf",   32'(bus.underflow), 32'd1);
    check("rw_empty_count", 32'(bus.count),     32'd1);
    check("rw_empty_dout",  32'(bus.data_out),  32'h44);
    step(1'b0, 1'b1, 8'h00);
    check("rw_empty_read", 32'(bus.data_out), 32'h77);
    check("rw_empty_after", 32'(bus.empty),   32'd1);

    // Read+write on full: both taken.
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    step(1'b1, 1'b1, 8'h66);
    check("rw_full_dout",  32'(bus.data_out), 32'h11);
    check("rw_full_count", 32'(bus.count),    32'd4);
    check("rw_full_ovf",   32'(bus.overflow), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("rw_full_d1", 32'(bus.data_out), 32'h22);
    step(1'b0, 1'b1, 8'h00);
    check("rw_full_d2", 32'(bus.data_out), 32'h33);
    step(1'b0, 1'b1, 8'h00);
    check("rw_full_d3", 32'(bus.data_out), 32'h44);
    step(1'b0, 1'b1, 8'h00);
    check("rw_full_d4", 32'(bus.data_out), 32'h66);
    check("rw_full_empty", 32'(bus.empty), 32'd1);

    // Write/read pairs crossing the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, W'(8'hC0 + i));
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("wrap%0d", i), 32'(bus.data_out), 32'(8'hC0 + i));
    end

    // Random traffic against a queue model, starting empty with data_out = 0xC9.
    exp_dout = 8'hC9;
    for (int c = 0; c < 1000; c++) begin
      we_r  = 1'($urandom_range(0, 1));
      re_r  = 1'($urandom_range(0, 1));
      din_r = W'($urandom_range(0, 255));
      rd_ok = re_r && (model_q.size() != 0);
      wr_ok = we_r && ((model_q.size() < L) || rd_ok);
      exp_ovf = we_r && !wr_ok;
      exp_unf = re_r && (model_q.size() == 0);
      if (rd_ok) exp_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(din_r);
      step(we_r, re_r, din_r);
      check($sformatf("rnd_dout%0d", c),  32'(bus.data_out),  32'(exp_dout));
      check($sformatf("rnd_count%0d", c), 32'(bus.count),     32'(model_q.size()));
      check($sformatf("rnd_ovf%0d", c),   32'(bus.overflow),  32'(exp_ovf));
      check($sformatf("rnd_unf%0d", c),   32'(bus.underflow), 32'(exp_unf));
    end
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
